// File: rtl/insn_emitter.sv
// insn_emitter: packs structured nic8 instructions into opcode/literal bytes and writes them to program memory
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   org_load, org_addr             reposition the write address (honoured only in IDLE)
//   req_valid/req_ready            instruction handshake
//   req_src, req_dst, req_indexed, req_cond, req_lit   instruction fields
//   mem_we, mem_addr, mem_wdata    byte-wide program memory write port
//   pc                             next address to be written
//   err, wrapped                   sticky status flags (cleared only by reset)
module insn_emitter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              org_load,
    input  logic [ADDR_W-1:0] org_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_src,
    input  logic [2:0]        req_dst,
    input  logic              req_indexed,
    input  logic [1:0]        req_cond,
    input  logic [7:0]        req_lit,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              err,
    output logic              wrapped
);
    typedef enum logic [1:0] {IDLE, OPCODE, LITERAL} state_t;
    state_t state, state_nxt;
    logic [7:0] op_byte, lit_byte;
    logic need_lit, accept, legal;

    assign legal  = req_dst != 3'd7;
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept && legal ? OPCODE : IDLE;
            OPCODE:  state_nxt = need_lit ? LITERAL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // reset_n gates ready so nothing is offered while reset is held
    always_comb begin
        req_ready = reset_n && state == IDLE && !org_load;
        mem_we    = state == OPCODE || state == LITERAL;
        mem_addr  = mem_we ? pc : '0;
        mem_wdata = state == OPCODE ? op_byte : state == LITERAL ? lit_byte : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pc       <= '0;
            op_byte  <= 8'h00;
            lit_byte <= 8'h00;
            need_lit <= 1'b0;
            err      <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            if (accept) begin
                op_byte  <= {req_cond, req_src, req_indexed, req_dst};
                lit_byte <= req_lit;
                need_lit <= req_src == 2'd0 && !req_indexed;
            end
            if (accept && !legal) err <= 1'b1;
            if (mem_we) begin
                pc <= pc + 1'b1;
                if (pc == {ADDR_W{1'b1}}) wrapped <= 1'b1;
            end else if (state == IDLE && org_load) begin
                pc <= org_addr;
            end
        end
endmodule

// File: tb/tb_insn_emitter.sv
// tb_insn_emitter: randomized and directed self-checking bench for insn_emitter
// A transaction-level model keeps a queue of bytes still to be written plus the
// expected pc/err/wrapped; one step task compares every cycle and advances the model.
module tb_insn_emitter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       org_load;
    logic [7:0] org_addr;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [2:0] req_dst;
    logic       req_indexed;
    logic [1:0] req_cond;
    logic [7:0] req_lit;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] pc;
    logic       err;
    logic       wrapped;

    insn_emitter #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .org_load(org_load), .org_addr(org_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_dst(req_dst),
        .req_indexed(req_indexed), .req_cond(req_cond), .req_lit(req_lit),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .err(err), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d;} wr_t;
    wr_t q[$];
    int  pc_m;
    bit  err_m, wrap_m;
    int  compared = 0, mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the negedge, compare against the model, then advance it.
    task automatic step(input logic ol, input logic [7:0] oa, input logic v, input logic [1:0] s,
                        input logic [2:0] d, input logic ix, input logic [1:0] c, input logic [7:0] l);
        wr_t w;
        org_load = ol; org_addr = oa; req_valid = v; req_src = s;
        req_dst = d; req_indexed = ix; req_cond = c; req_lit = l;
        #1;
        chk("mem_we", mem_we, q.size() > 0);
        if (q.size() > 0) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
        end
        chk("pc", pc, pc_m);
        chk("err", err, err_m);
        chk("wrapped", wrapped, wrap_m);
        chk("req_ready", req_ready, q.size() == 0 && !ol);
        @(posedge clk);
        if (q.size() > 0) begin
            void'(q.pop_front());
            if (pc_m == 255) wrap_m = 1;
            pc_m = (pc_m + 1) % 256;
        end else if (ol) begin
            pc_m = oa;
        end else if (v) begin
            if (d == 3'd7) err_m = 1;
            else begin
                w.a = pc_m; w.d = c * 64 + s * 16 + ix * 8 + d;
                q.push_back(w);
                if (s == 2'd0 && !ix) begin
                    w.a = (pc_m + 1) % 256; w.d = l;
                    q.push_back(w);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 2'd0, 3'd0, 0, 2'd0, 8'h00);
    endtask

    initial begin
        reset_n = 0; org_load = 0; org_addr = 0; req_valid = 0; req_src = 0;
        req_dst = 0; req_indexed = 0; req_cond = 0; req_lit = 0;
        pc_m = 0; err_m = 0; wrap_m = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", pc, 0);
        reset_n = 1;
        // plain move A->B
        step(0, 8'h00, 1, 2'd2, 3'd3, 0, 2'd0, 8'h00);
        chk("mov_we", mem_we, 1);
        chk("mov_addr", mem_addr, 8'h00);
        chk("mov_data", mem_wdata, 8'h23);
        idle();
        chk("mov_pc", pc, 8'h01);
        chk("mov_ready", req_ready, 1);
        // org 0x10 then literal load into A
        step(1, 8'h10, 0, 2'd0, 3'd0, 0, 2'd0, 8'h00);
        step(0, 8'h00, 1, 2'd0, 3'd2, 0, 2'd0, 8'h5A);
        chk("ldi_op_addr", mem_addr, 8'h10);
        chk("ldi_op_data", mem_wdata, 8'h02);
        chk("ldi_ready1", req_ready, 0);
        idle();
        chk("ldi_lit_addr", mem_addr, 8'h11);
        chk("ldi_lit_data", mem_wdata, 8'h5A);
        chk("ldi_ready2", req_ready, 0);
        idle();
        chk("ldi_pc", pc, 8'h12);
        // unconditional indexed jump
        step(0, 8'h00, 1, 2'd0, 3'd1, 1, 2'd3, 8'h77);
        chk("jmp_data", mem_wdata, 8'hC9);
        idle();
        chk("jmp_nolit", mem_we, 0);
        // illegal dest then a legal request
        step(0, 8'h00, 1, 2'd1, 3'd7, 0, 2'd0, 8'h00);
        chk("ill_err", err, 1);
        chk("ill_we", mem_we, 0);
        chk("ill_pc", pc, 8'h13);
        step(0, 8'h00, 1, 2'd3, 3'd4, 0, 2'd1, 8'h00);
        chk("post_ill_data", mem_wdata, 8'h74);
        chk("post_ill_err", err, 1);
        idle();
        // straddle the wrap
        step(1, 8'hFF, 0, 2'd0, 3'd0, 0, 2'd0, 8'h00);
        step(0, 8'h00, 1, 2'd0, 3'd2, 0, 2'd0, 8'hA5);
        chk("wrap_op_addr", mem_addr, 8'hFF);
        chk("wrap_op_data", mem_wdata, 8'h02);
        idle();
        chk("wrap_lit_addr", mem_addr, 8'h00);
        chk("wrap_lit_data", mem_wdata, 8'hA5);
        idle();
        chk("wrap_pc", pc, 8'h01);
        chk("wrap_flag", wrapped, 1);
        // org_load beats a simultaneous request
        step(1, 8'h40, 1, 2'd2, 3'd3, 0, 2'd0, 8'h00);
        chk("org_pri_we", mem_we, 0);
        chk("org_pri_pc", pc, 8'h40);
        idle();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic ol, v, ix;
            logic [7:0] oa, l;
            logic [1:0] s, c;
            logic [2:0] d;
            ol = $urandom_range(0, 9) == 0;
            oa = $urandom_range(0, 3) == 0 ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            v  = $urandom_range(0, 9) < 7;
            s  = 2'($urandom);
            d  = $urandom_range(0, 19) == 0 ? 3'd7 : 3'($urandom_range(0, 6));
            ix = 1'($urandom);
            c  = 2'($urandom);
            l  = 8'($urandom);
            step(ol, oa, v, s, d, ix, c, l);
        end
        // reset in the middle of a literal write
        step(1, 8'h20, 0, 2'd0, 3'd0, 0, 2'd0, 8'h00);
        step(0, 8'h00, 1, 2'd0, 3'd3, 0, 2'd2, 8'h3C);
        idle();
        chk("pre_rst_lit", mem_wdata, 8'h3C);
        #2 reset_n = 0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_err", err, 0);
        chk("midrst_wrap", wrapped, 0);
        q.delete(); pc_m = 0; err_m = 0; wrap_m = 0;
        @(negedge clk);
        reset_n = 1;
        idle();
        step(0, 8'h00, 1, 2'd2, 3'd3, 0, 2'd0, 8'h00);
        chk("after_rst_addr", mem_addr, 8'h00);
        chk("after_rst_data", mem_wdata, 8'h23);
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
